// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer with wrap-bit pointers and flush.
// Optional same-cycle empty-queue bypass when IFQ_BYPASS_EN is defined.
module if_id_queue #(
    parameter int DEPTH     = 4,
    parameter int CPU_WIDTH = 64,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [CPU_WIDTH-1:0] i_in_pc,
    input  logic [31:0]          i_in_inst,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [CPU_WIDTH-1:0] o_out_pc,
    output logic [31:0]          o_out_inst,
    output logic [PTR_W:0]       o_count
);

    logic [CPU_WIDTH-1:0] r_mem_pc   [DEPTH];
    logic [31:0]          r_mem_inst [DEPTH];
    logic [PTR_W:0]       r_wr_ptr;
    logic [PTR_W:0]       r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_enq;
    logic w_deq;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_empty && i_in_valid && !i_flush && !i_rst;
`else
    assign w_byp = 1'b0;
`endif

    assign o_in_ready  = !w_full && !i_rst;
    assign o_out_valid = (!w_empty || w_byp) && !i_flush && !i_rst;
    assign o_count     = r_wr_ptr - r_rd_ptr;

    // A bypassed entry that decode takes at once is never stored.
    assign w_enq = i_in_valid && o_in_ready && !i_flush &&
                   !(w_byp && i_out_ready);
    assign w_deq = o_out_valid && i_out_ready && !w_empty;

    always_comb begin
        o_out_pc   = '0;
        o_out_inst = '0;
        if (o_out_valid) begin
            if (!w_empty) begin
                o_out_pc   = r_mem_pc[r_rd_ptr[PTR_W-1:0]];
                o_out_inst = r_mem_inst[r_rd_ptr[PTR_W-1:0]];
            end else begin
                o_out_pc   = i_in_pc;
                o_out_inst = i_in_inst;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_mem_pc[r_wr_ptr[PTR_W-1:0]]   <= i_in_pc;
            r_mem_inst[r_wr_ptr[PTR_W-1:0]] <= i_in_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed-vector bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_pc     (in_pc),
        .i_in_inst   (in_inst),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_pc    (out_pc),
        .o_out_inst  (out_inst),
        .o_count     (count)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic iv, logic [63:0] pc,
                                logic [31:0] inst, logic ordy, logic e_irdy,
                                logic e_ov, logic [63:0] e_pc,
                                logic [31:0] e_inst, logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [63:0] pc,
                         input logic [31:0] inst, input logic ordy);
        flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 64'h0, 32'h0, 0);
        #1;
        chk("reset_state", {in_ready, out_valid, out_pc, out_inst, count},
            {1'b0, 1'b0, 64'h0, 32'h0, 3'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {in_ready, out_valid, count}, {1'b1, 1'b0, 3'd0});

        // fill, full-with-pop, drain
        vecs.push_back(mk(0,1,64'h8000_0000,32'h00000013,0, 1,0,64'h0,32'h0,3'd0));
        vecs.push_back(mk(0,1,64'h8000_0004,32'h00100093,0, 1,1,64'h8000_0000,32'h00000013,3'd1));
        vecs.push_back(mk(0,1,64'h8000_0008,32'h00200113,0, 1,1,64'h8000_0000,32'h00000013,3'd2));
        vecs.push_back(mk(0,1,64'h8000_000C,32'h00300193,0, 1,1,64'h8000_0000,32'h00000013,3'd3));
        vecs.push_back(mk(0,1,64'h8000_0010,32'h00400213,0, 0,1,64'h8000_0000,32'h00000013,3'd4));
        vecs.push_back(mk(0,1,64'h8000_0010,32'h00400213,1, 0,1,64'h8000_0000,32'h00000013,3'd4));
        vecs.push_back(mk(0,1,64'h8000_0010,32'h00400213,0, 1,1,64'h8000_0004,32'h00100093,3'd3));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 0,1,64'h8000_0004,32'h00100093,3'd4));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 1,1,64'h8000_0008,32'h00200113,3'd3));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 1,1,64'h8000_000C,32'h00300193,3'd2));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 1,1,64'h8000_0010,32'h00400213,3'd1));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 1,0,64'h0,32'h0,3'd0));
        // flush with data queued plus a wrong-path input
        vecs.push_back(mk(0,1,64'h8000_0020,32'h00500293,0, 1,0,64'h0,32'h0,3'd0));
        vecs.push_back(mk(0,1,64'h8000_0024,32'h00600313,0, 1,1,64'h8000_0020,32'h00500293,3'd1));
        vecs.push_back(mk(0,1,64'h8000_0028,32'h00700393,0, 1,1,64'h8000_0020,32'h00500293,3'd2));
        vecs.push_back(mk(1,1,64'h8000_0010,32'h00800413,1, 1,0,64'h0,32'h0,3'd3));
        vecs.push_back(mk(0,1,64'h8000_0100,32'h00900493,0, 1,0,64'h0,32'h0,3'd0));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 1,1,64'h8000_0100,32'h00900493,3'd1));
        vecs.push_back(mk(0,0,64'h0,32'h0,1, 1,0,64'h0,32'h0,3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d", i),
                {in_ready, out_valid, out_pc, out_inst, count},
                {vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_inst,
                 vecs[i].e_cnt});
        end

        // streaming at full rate
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(0, 1, 64'h9000_0000 + 64'(4 * k), 32'(k), 1);
            #1;
`ifdef IFQ_BYPASS_EN
            chk($sformatf("stream%0d", k), {out_valid, out_pc, count},
                {1'b1, 64'h9000_0000 + 64'(4 * k), 3'd0});
`else
            if (k == 0)
                chk("stream0", {out_valid, count}, {1'b0, 3'd0});
            else
                chk($sformatf("stream%0d", k), {out_valid, out_pc, count},
                    {1'b1, 64'h9000_0000 + 64'(4 * (k - 1)), 3'd1});
`endif
        end
        @(negedge clk);
        drive(0, 0, 64'h0, 32'h0, 1);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("stream_tail", {out_valid, count}, {1'b0, 3'd0});
`else
        chk("stream_tail", {out_valid, out_pc, count},
            {1'b1, 64'h9000_0000 + 64'(4 * 19), 3'd1});
`endif
        @(negedge clk);
        drive(0, 0, 64'h0, 32'h0, 0);
        #1;
        chk("stream_empty", {out_valid, count}, {1'b0, 3'd0});

        // wrap-around: push 3 / pop 3
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                drive(0, 1, 64'hA000_0000 + 64'(12 * r + 4 * j), 32'(r * 3 + j), 0);
                #1;
                chk($sformatf("wrap_push_r%0d_%0d", r, j), {count}, {3'(j)});
            end
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                drive(0, 0, 64'h0, 32'h0, 1);
                #1;
                chk($sformatf("wrap_pop_r%0d_%0d", r, j),
                    {out_valid, out_pc, out_inst, count},
                    {1'b1, 64'hA000_0000 + 64'(12 * r + 4 * j), 32'(r * 3 + j),
                     3'(3 - j)});
            end
            @(negedge clk);
            drive(0, 0, 64'h0, 32'h0, 0);
            #1;
            chk($sformatf("wrap_empty_r%0d", r), {out_valid, count}, {1'b0, 3'd0});
        end

        // asynchronous reset between edges
        @(negedge clk);
        drive(0, 1, 64'hB000_0000, 32'h11, 0);
        @(negedge clk);
        drive(0, 1, 64'hB000_0004, 32'h22, 0);
        @(negedge clk);
        drive(0, 0, 64'h0, 32'h0, 0);
        #1;
        chk("pre_async_rst", {out_valid, out_pc, count}, {1'b1, 64'hB000_0000, 3'd2});
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", {in_ready, out_valid, out_pc, out_inst, count},
            {1'b0, 1'b0, 64'h0, 32'h0, 3'd0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_async_rst", {in_ready, out_valid, count}, {1'b1, 1'b0, 3'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
